// File: rtl/kbd_pkg.sv
// Shared types, key codes and decode helpers for the 4x4 keypad scanner.
package kbd_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_t;

    localparam logic [3:0] KEY_STAR  = 4'hE;
    localparam logic [3:0] KEY_HASH  = 4'hF;

    // All rows released (rows are active-low).
    localparam logic [3:0] ROWS_IDLE = 4'b1111;
    // Column drive after reset: column 0 selected (active-low one-hot).
    localparam logic [3:0] COL_FIRST = 4'b1110;

    // Keypad legend: row r, column c -> hex key code.
    function automatic logic [3:0] key_map(input logic [1:0] row_idx,
                                           input logic [1:0] col_idx);
        logic [3:0] code;
        code = 4'h0;
        case ({row_idx, col_idx})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = 4'h0;
            4'b11_10: code = KEY_HASH;
            4'b11_11: code = 4'hD;
            default:  code = 4'h0;
        endcase
        return code;
    endfunction

    // Lowest-index low row wins when several rows are pulled down together.
    function automatic logic [1:0] low_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        if (!rows[0])      idx = 2'd0;
        else if (!rows[1]) idx = 2'd1;
        else if (!rows[2]) idx = 2'd2;
        else if (!rows[3]) idx = 2'd3;
        return idx;
    endfunction

    // Index of the column currently driven low.
    function automatic logic [1:0] col_index(input logic [3:0] col);
        logic [1:0] idx;
        idx = 2'd0;
        if (!col[0])      idx = 2'd0;
        else if (!col[1]) idx = 2'd1;
        else if (!col[2]) idx = 2'd2;
        else if (!col[3]) idx = 2'd3;
        return idx;
    endfunction

    // Advance the active-low one-hot column drive: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
    function automatic logic [3:0] next_col(input logic [3:0] col);
        return {col[2:0], col[3]};
    endfunction

endpackage

// File: rtl/kbd_scanner_sync2.sv
// Two-flop synchronizer for asynchronous inputs, reset to a chosen idle value.
module sync2 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two register stages give metastability time to resolve before use.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/kbd_scanner.sv
// Column-locking 4x4 keypad scanner: debounces presses and releases on a slow
// sample tick and emits one key_valid strobe per accepted press.
module kbd_scanner
    import kbd_pkg::*;
#(
    parameter int SCAN_DIV    = 27000,
    parameter int DEB_SAMPLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] fil,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int TW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEB_SAMPLES + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEB_SAMPLES - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEB_SAMPLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [3:0]    fs;
    logic [TW-1:0] tcnt;
    logic          tick;

    state_t        state, state_n;
    logic [3:0]    col_n;
    logic [3:0]    samp, samp_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW-1:0] rel_cnt, rel_n;
    logic [3:0]    code_n;
    logic          valid_n;
    logic          held_n;
    logic          press;

    sync2 #(
        .WIDTH     (4),
        .RESET_VAL (ROWS_IDLE)
    ) u_fil_sync (
        .clk (clk),
        .rst (rst),
        .d   (fil),
        .q   (fs)
    );

    assign tick = (tcnt == TICK_LAST);

    // Free-running sample/dwell divider; it keeps counting in every state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt <= '0;
        end else if (tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SCAN;
            col       <= COL_FIRST;
            samp      <= ROWS_IDLE;
            cnt       <= '0;
            rel_cnt   <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            col       <= col_n;
            samp      <= samp_n;
            cnt       <= cnt_n;
            rel_cnt   <= rel_n;
            key_code  <= code_n;
            key_valid <= valid_n;
            key_held  <= held_n;
        end
    end

    // Next-state logic: all decisions are taken on tick only; key_valid
    // defaults low so it can never stretch beyond one cycle.
    always_comb begin
        state_n = state;
        col_n   = col;
        samp_n  = samp;
        cnt_n   = cnt;
        rel_n   = rel_cnt;
        code_n  = key_code;
        valid_n = 1'b0;
        held_n  = key_held;
        press   = 1'b0;

        if (tick) begin
            unique case (state)
                SCAN: begin
                    if (fs == ROWS_IDLE) begin
                        col_n = next_col(col);
                    end else begin
                        // Column freezes here; only this column's keys are seen.
                        samp_n = fs;
                        cnt_n  = CNT_ONE;
                        if (DEB_SAMPLES == 1) begin
                            press = 1'b1;
                        end else begin
                            state_n = DEBOUNCE;
                        end
                    end
                end

                DEBOUNCE: begin
                    if (fs == samp) begin
                        if (cnt == CNT_LAST) begin
                            cnt_n = CNT_FULL;
                            press = 1'b1;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end else if (fs == ROWS_IDLE) begin
                        // Bounced back to idle: give up and let rotation resume
                        // from the current column on the next tick.
                        state_n = SCAN;
                        samp_n  = ROWS_IDLE;
                        cnt_n   = '0;
                    end else begin
                        // A different row pattern restarts the count on it.
                        samp_n = fs;
                        cnt_n  = CNT_ONE;
                    end
                end

                PRESSED: begin
                    // Row changes while held are ignored; only a clean
                    // all-released run ends the press.
                    if (fs == ROWS_IDLE) begin
                        if (rel_cnt == CNT_LAST) begin
                            state_n = SCAN;
                            held_n  = 1'b0;
                            col_n   = next_col(col);
                            rel_n   = '0;
                            samp_n  = ROWS_IDLE;
                            cnt_n   = '0;
                        end else begin
                            rel_n = rel_cnt + 1'b1;
                        end
                    end else begin
                        rel_n = '0;
                    end
                end

                default: begin
                    state_n = SCAN;
                end
            endcase
        end

        // Press accepted: fs equals samp on this tick, so decode from fs.
        if (press) begin
            state_n = PRESSED;
            code_n  = key_map(low_row(fs), col_index(col));
            valid_n = 1'b1;
            held_n  = 1'b1;
            rel_n   = '0;
        end
    end

endmodule

// File: tb/tb_kbd_scanner.sv
// Directed bench for kbd_scanner with SCAN_DIV = 4 and DEB_SAMPLES = 3.
module tb_kbd_scanner;

    localparam int SCAN_DIV    = 4;
    localparam int DEB_SAMPLES = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] fil = 4'b1111;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int         n_checks = 0;
    int         n_errors = 0;
    int         edge_n   = 0;
    int         ev_cnt   = 0;
    logic [3:0] ev_code  = 4'h0;
    int         lost     = 0;

    kbd_scanner #(
        .SCAN_DIV    (SCAN_DIV),
        .DEB_SAMPLES (DEB_SAMPLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fil       (fil),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; every SCAN_DIV-th edge is a tick edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) edge_n = 0;
        else      edge_n = edge_n + 1;
    end

    // Key event monitor.
    always @(negedge clk) begin
        if (key_valid) begin
            ev_cnt  = ev_cnt + 1;
            ev_code = key_code;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Return just after the next tick edge.
    task automatic to_tick();
        do @(negedge clk); while (edge_n % SCAN_DIV != 0);
        #1;
    endtask

    task automatic wait_col(input string tag, input logic [3:0] target);
        int n;
        n = 0;
        while (col != target && n < 8) begin
            to_tick();
            n++;
        end
        chk(tag, col, target);
    endtask

    task automatic release_key(input string tag, input logic [3:0] exp_col);
        int n;
        fil = 4'b1111;
        n = 0;
        while (key_held && n < 10) begin
            to_tick();
            n++;
        end
        chk({tag, "_ticks"}, n, DEB_SAMPLES);
        chk({tag, "_col"}, col, exp_col);
    endtask

    initial begin
        // 1: reset
        repeat (5) @(negedge clk);
        chk("t1_col", col, 4'b1110);
        chk("t1_code", key_code, 4'h0);
        chk("t1_valid", key_valid, 1'b0);
        chk("t1_held", key_held, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("t1_col_hold", col, 4'b1110);
        @(negedge clk);
        chk("t1_col_rot", col, 4'b1101);

        // 2: clean press of '6'
        wait_col("t2_wcol", 4'b1011);
        ev_cnt = 0;
        fil = 4'b1101;
        to_tick();
        to_tick();
        chk("t2_early", key_valid, 1'b0);
        to_tick();
        chk("t2_valid", key_valid, 1'b1);
        chk("t2_code", key_code, 4'h6);
        chk("t2_held", key_held, 1'b1);
        @(negedge clk);
        #1;
        chk("t2_pulse", key_valid, 1'b0);
        chk("t2_events", ev_cnt, 1);
        release_key("t2_rel", 4'b0111);

        // 3: bounce on '1': 2 low ticks, 1 high, 3 low
        wait_col("t3_wcol", 4'b1110);
        ev_cnt = 0;
        fil = 4'b1110;
        to_tick();
        to_tick();
        fil = 4'b1111;
        to_tick();
        chk("t3_col_frozen", col, 4'b1110);
        fil = 4'b1110;
        to_tick();
        to_tick();
        chk("t3_early", key_valid, 1'b0);
        chk("t3_no_ev", ev_cnt, 0);
        to_tick();
        chk("t3_valid", key_valid, 1'b1);
        chk("t3_code", key_code, 4'h1);
        release_key("t3_rel", 4'b1101);
        chk("t3_events", ev_cnt, 1);

        // 4: long hold of '#'
        wait_col("t4_wcol", 4'b1011);
        ev_cnt = 0;
        lost = 0;
        fil = 4'b0111;
        for (int i = 0; i < 100; i++) begin
            to_tick();
            if (i >= DEB_SAMPLES - 1 && !key_held) lost++;
        end
        chk("t4_events", ev_cnt, 1);
        chk("t4_code", ev_code, 4'hF);
        chk("t4_held_drops", lost, 0);
        release_key("t4_rel", 4'b0111);

        // 5: rows 0 and 2 together on column 3
        wait_col("t5_wcol", 4'b0111);
        ev_cnt = 0;
        fil = 4'b1010;
        repeat (6) to_tick();
        chk("t5_events", ev_cnt, 1);
        chk("t5_code", ev_code, 4'hA);
        release_key("t5_rel", 4'b1110);

        // 6: reset in the middle of debouncing '7'
        wait_col("t6_wcol", 4'b1110);
        ev_cnt = 0;
        fil = 4'b1011;
        to_tick();
        to_tick();
        rst = 1'b0;
        #1;
        chk("t6_col", col, 4'b1110);
        chk("t6_code", key_code, 4'h0);
        chk("t6_valid", key_valid, 1'b0);
        chk("t6_held", key_held, 1'b0);
        repeat (3) @(negedge clk);
        chk("t6_no_ev_rst", ev_cnt, 0);
        rst = 1'b1;
        to_tick();
        to_tick();
        chk("t6_early", key_valid, 1'b0);
        chk("t6_no_ev", ev_cnt, 0);
        to_tick();
        chk("t6_valid", key_valid, 1'b1);
        chk("t6_code", key_code, 4'h7);
        release_key("t6_rel", 4'b1101);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/kbd_scanner.md
# kbd_scanner

Debounced 4x4 matrix-keypad scanner producing one-shot key events. Sits directly upstream of the key-capture FSM. Replaces the separate per-row debounce plus free-running scan with one column-locking machine, and delivers a hex key code with a single-cycle valid strobe per physical press.

## Interface
Parameters:
- SCAN_DIV, 27000: clk cycles per column dwell and per sample tick (1 ms at 27 MHz); must be ≥ 2.
- DEB_SAMPLES, 8: consecutive identical row samples required to accept a press or a release; must be ≥ 1.

Ports:
- clk  in  1  system clock, 27 MHz.
- rst  in  1  reset. Asynchronous, active-low (0 = reset).
- fil  in  4  keypad rows, active-low, asynchronous to clk.
- col  out  4  keypad columns, active-low one-hot drive.
- key_code  out  4  code of the last accepted key.
- key_valid  out  1  one-cycle strobe when key_code is updated.
- key_held  out  1  high while the accepted key is still considered pressed.

## Operation
- fil passes through a 2-flop synchronizer, giving fs. All decisions use fs.
- Tick: a counter wraps at SCAN_DIV-1. tick = 1 in the wrap cycle. The counter runs in every state.
- Key map, listed as row r (fil[r]) and col c (col[c] low):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: *=E, 0, #=F, D
- States:
  - SCAN:
    - On tick with fs == 4'b1111, rotate col to the next column (1110 → 1101 → 1011 → 0111 → 1110).
    - On tick with any fs bit low, capture fs into samp, set cnt = 1, and go to DEBOUNCE. col is frozen.
  - DEBOUNCE:
    - On tick with fs == samp, increment cnt. When cnt reaches DEB_SAMPLES, go to PRESSED. If DEB_SAMPLES == 1, PRESSED is entered on the capture tick itself.
    - On tick with fs != samp: if fs == 1111, go to SCAN and resume rotation. Otherwise reload samp = fs and cnt = 1.
  - PRESSED:
    - On entry, drive key_code = map(lowest-index low row of samp, active column) and pulse key_valid for exactly one cycle. key_held = 1.
    - Release: after DEB_SAMPLES consecutive ticks with fs == 1111, drive key_held = 0, go to SCAN, and advance col to the next column.
    - Any non-1111 tick resets the release count.
    - Changes among low rows in PRESSED never generate a new event.
- Multiple rows low in the same column: the lowest row index wins.
- Keys in other columns are not seen while col is frozen (no n-key rollover).
- key_code holds its value until the next accepted press.

## Timing
- Reset values: col = 4'b1110, key_code = 4'h0, key_valid = 0, key_held = 0, state = SCAN, tick counter = 0, samp = 4'b1111, cnt = 0.
- Asserting rst mid-operation forces all of the above immediately. No event is emitted after rst is released until a full debounce completes.
- Input latency: 2 clk for the synchronizer.
- Press latency: key_valid rises in the clk cycle after the tick that completes DEB_SAMPLES matching samples. That is at most (4+DEB_SAMPLES)·SCAN_DIV + 3 clk after the row settles.
- key_valid is asserted in the same cycle key_code takes its new value. Consumers sample on key_valid == 1.
- key_held rises with key_valid. It falls one cycle after the DEB_SAMPLES-th consecutive release tick.
- Bounce: a glitch shorter than one tick period that is not sampled has no effect. A sampled glitch restarts the count.

## Structure
- Package kbd_pkg holds:
  - state_t enum {SCAN, DEBOUNCE, PRESSED}, 2-bit.
  - key-code localparams (KEY_STAR = 4'hE, KEY_HASH = 4'hF).
  - function key_map(row_idx, col_idx) returning logic [3:0].
- Sub-module sync2 (2-flop synchronizer, width parameter) is instantiated once for fil. The tick counter and FSM stay inline.

## Test plan
Bench parameters: SCAN_DIV = 4, DEB_SAMPLES = 3.
1. Reset: hold rst = 0 for 5 clk with fil = 1111. Required: col = 1110, key_code = 0, key_valid = 0, key_held = 0. col rotates to 1101 four clk after release.
2. Clean press: drive fil[1] = 0 only while col == 1011, then hold. Required: one key_valid pulse with key_code = 4'h6 and key_held = 1. After fil = 1111 for 3 ticks, key_held = 0 and col advances to 0111.
3. Bounce: toggle fil[0] on col 1110 with a pattern of 2 low ticks, 1 high, then 3 low. Required: exactly one key_valid with key_code = 4'h1, at the third consecutive low tick.
4. Long hold: hold '#' (fil[3], col 1011) for 100 ticks. Required: a single key_valid with key_code = 4'hF and key_held = 1 throughout.
5. Two rows: fil = 1010 (rows 0 and 2) on col 0111. Required: key_code = 4'hA (row 0 wins), one event.
6. Mid-debounce reset: assert rst after 2 matching ticks. Required: no key_valid, outputs at reset values. After release with the key still held, a full debounce of 3 ticks precedes key_valid.
